// File: rtl/lt24_pixel_bus_writer.sv
// Pixel-interface responder that streams pixels onto the LT24 8080-style write bus.
// Optional running checksum is built when LT24_PIXEL_CHECKSUM_EN is defined.
module lt24_pixel_bus_writer #(
  parameter int unsigned LCD_WIDTH      = 240,
  parameter int unsigned LCD_HEIGHT     = 320,
  parameter int unsigned WR_LOW_CYCLES  = 2,
  parameter int unsigned WR_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        globalReset_n,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic        LT24Wr_n,
  output logic [15:0] LT24Data,
  output logic [15:0] frameChecksum
);

  typedef enum logic [1:0] {StIdle, StWrLow, StWrHigh, StRangeDrop} state_e;

  localparam logic [15:0] WidthLast  = 16'(LCD_WIDTH - 1);
  localparam logic [15:0] HeightLast = 16'(LCD_HEIGHT - 1);
  localparam logic [7:0]  LowLast    = 8'(WR_LOW_CYCLES - 1);
  localparam logic [7:0]  HighLast   = 8'(WR_HIGH_CYCLES - 1);
  localparam logic [3:0]  LastWord   = 4'd11;

  state_e      state;
  logic [7:0]  cnt;
  logic [3:0]  wordIdx;
  logic [7:0]  xLat;
  logic [8:0]  yLat;
  logic [15:0] pixLat;
  logic        seqValid;
  logic [7:0]  expX;
  logic [8:0]  expY;

  logic        accept;
  logic        inRange;
  logic        hit;
  logic [3:0]  nextIdx;
  logic        nextRs;
  logic [15:0] nextData;

  assign accept  = (state == StIdle) && pixelReady && pixelWrite;
  assign inRange = (32'(xAddr) < LCD_WIDTH) && (32'(yAddr) < LCD_HEIGHT);
  assign hit     = seqValid && (xAddr == expX) && (yAddr == expY);
  assign nextIdx = wordIdx + 4'd1;

  // Word table of the address-window preamble; index 11 is always the pixel itself.
  always_comb begin
    nextRs   = 1'b1;
    nextData = 16'h0000;
    case (nextIdx)
      4'd0:    begin nextRs = 1'b0; nextData = 16'h002A; end
      4'd1:    nextData = 16'h0000;
      4'd2:    nextData = {8'h00, xLat};
      4'd3:    nextData = {8'h00, WidthLast[15:8]};
      4'd4:    nextData = {8'h00, WidthLast[7:0]};
      4'd5:    begin nextRs = 1'b0; nextData = 16'h002B; end
      4'd6:    nextData = {15'h0000, yLat[8]};
      4'd7:    nextData = {8'h00, yLat[7:0]};
      4'd8:    nextData = {8'h00, HeightLast[15:8]};
      4'd9:    nextData = {8'h00, HeightLast[7:0]};
      4'd10:   begin nextRs = 1'b0; nextData = 16'h002C; end
      default: nextData = pixLat;
    endcase
  end

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      state      <= StIdle;
      pixelReady <= 1'b0;
      LT24CS_n   <= 1'b1;
      LT24RS     <= 1'b1;
      LT24Wr_n   <= 1'b1;
      LT24Data   <= 16'h0000;
      cnt        <= 8'h00;
      wordIdx    <= 4'd0;
      xLat       <= 8'h00;
      yLat       <= 9'h000;
      pixLat     <= 16'h0000;
      seqValid   <= 1'b0;
      expX       <= 8'h00;
      expY       <= 9'h000;
    end else begin
      unique case (state)
        StIdle: begin
          pixelReady <= 1'b1;
          LT24CS_n   <= 1'b1;
          if (accept) begin
            pixelReady <= 1'b0;
            xLat       <= xAddr;
            yLat       <= yAddr;
            pixLat     <= pixelData;
            cnt        <= 8'h00;
            if (!inRange) begin
              state <= StRangeDrop;
            end else begin
              state    <= StWrLow;
              LT24CS_n <= 1'b0;
              LT24Wr_n <= 1'b0;
              if (hit) begin
                wordIdx  <= LastWord;
                LT24RS   <= 1'b1;
                LT24Data <= pixelData;
              end else begin
                wordIdx  <= 4'd0;
                LT24RS   <= 1'b0;
                LT24Data <= 16'h002A;
              end
            end
          end
        end
        StWrLow: begin
          if (cnt == LowLast) begin
            cnt      <= 8'h00;
            LT24Wr_n <= 1'b1;
            state    <= StWrHigh;
          end else begin
            cnt <= cnt + 8'h01;
          end
        end
        StWrHigh: begin
          if (cnt == HighLast) begin
            cnt <= 8'h00;
            if (wordIdx == LastWord) begin
              state      <= StIdle;
              pixelReady <= 1'b1;
              LT24CS_n   <= 1'b1;
              seqValid   <= 1'b1;
              // Raster successor; the bottom-right corner wraps to the origin.
              if (32'(xLat) < LCD_WIDTH - 1) begin
                expX <= xLat + 8'h01;
                expY <= yLat;
              end else if (32'(yLat) < LCD_HEIGHT - 1) begin
                expX <= 8'h00;
                expY <= yLat + 9'h001;
              end else begin
                expX <= 8'h00;
                expY <= 9'h000;
              end
            end else begin
              wordIdx  <= nextIdx;
              LT24RS   <= nextRs;
              LT24Data <= nextData;
              LT24Wr_n <= 1'b0;
              state    <= StWrLow;
            end
          end else begin
            cnt <= cnt + 8'h01;
          end
        end
        StRangeDrop: begin
          seqValid   <= 1'b0;
          pixelReady <= 1'b1;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef LT24_PIXEL_CHECKSUM_EN
  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      frameChecksum <= 16'h0000;
    end else if (accept && inRange) begin
      frameChecksum <= (xAddr == 8'h00 && yAddr == 9'h000) ? pixelData :
                       ({frameChecksum[14:0], frameChecksum[15]} ^ pixelData);
    end
  end
`else
  assign frameChecksum = 16'h0000;
`endif

endmodule

// File: tb/tb_lt24_pixel_bus_writer.sv
// Self-checking bench for lt24_pixel_bus_writer: directed scenarios plus random pixels
// compared against a raster-index reference model.
module tb_lt24_pixel_bus_writer;

  localparam int W  = 240;
  localparam int H  = 320;
  localparam int WL = 2;
  localparam int WH = 2;

  logic        clock = 1'b0;
  logic        globalReset_n = 1'b0;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady;
  logic        LT24CS_n;
  logic        LT24RS;
  logic        LT24Wr_n;
  logic [15:0] LT24Data;
  logic [15:0] frameChecksum;

  lt24_pixel_bus_writer #(
    .LCD_WIDTH(W), .LCD_HEIGHT(H), .WR_LOW_CYCLES(WL), .WR_HIGH_CYCLES(WH)
  ) dut (
    .clock(clock), .globalReset_n(globalReset_n), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Wr_n(LT24Wr_n), .LT24Data(LT24Data),
    .frameChecksum(frameChecksum)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Bus capture: one {RS,Data} entry per Wr_n rising edge.
  logic [16:0] wq[$];
  logic        prevWr = 1'b1;
  int          csBad = 0;
  always @(negedge clock) begin
    if (!globalReset_n) begin
      prevWr = 1'b1;
    end else begin
      if (!prevWr && LT24Wr_n) wq.push_back({LT24RS, LT24Data});
      if (!LT24Wr_n && LT24CS_n) csBad++;
      prevWr = LT24Wr_n;
    end
  end

  // Reference model: expected next pixel kept as a linear raster index.
  logic [16:0] expQ[$];
  int          expLat;
  bit          mSeqValid = 1'b0;
  int          mNextIdx = 0;
  logic [15:0] mSum = 16'h0000;

  function automatic void modelPixel(int x, int y, logic [15:0] d);
    expQ.delete();
    if (x >= W || y >= H) begin
      mSeqValid = 1'b0;
      expLat = 1;
      return;
    end
    if (!(mSeqValid && (y * W + x) == mNextIdx)) begin
      expQ.push_back({1'b0, 16'h002A});
      expQ.push_back({1'b1, 16'h0000});
      expQ.push_back({1'b1, 16'(x)});
      expQ.push_back({1'b1, 16'((W - 1) / 256)});
      expQ.push_back({1'b1, 16'((W - 1) % 256)});
      expQ.push_back({1'b0, 16'h002B});
      expQ.push_back({1'b1, 16'(y / 256)});
      expQ.push_back({1'b1, 16'(y % 256)});
      expQ.push_back({1'b1, 16'((H - 1) / 256)});
      expQ.push_back({1'b1, 16'((H - 1) % 256)});
      expQ.push_back({1'b0, 16'h002C});
    end
    expQ.push_back({1'b1, d});
    expLat = expQ.size() * (WL + WH);
    mNextIdx = (y * W + x + 1) % (W * H);
    mSeqValid = 1'b1;
`ifdef LT24_PIXEL_CHECKSUM_EN
    mSum = (x == 0 && y == 0) ? d : ({mSum[14:0], mSum[15]} ^ d);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendPixel(input int x, input int y, input logic [15:0] d);
    int n;
    int lowCnt;
    n = 0;
    while (!pixelReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", 32'(pixelReady), 32'd1);
    wq.delete();
    xAddr = 8'(x);
    yAddr = 9'(y);
    pixelData = d;
    pixelWrite = 1'b1;
    modelPixel(x, y, d);
    @(negedge clock);
    pixelWrite = 1'b0;
    lowCnt = 0;
    while (!pixelReady && lowCnt < 200) begin
      lowCnt++;
      @(negedge clock);
    end
    check("ready_low_cycles", 32'(lowCnt), 32'(expLat));
    check("write_count", 32'(wq.size()), 32'(expQ.size()));
    for (int i = 0; i < wq.size() && i < expQ.size(); i++) begin
      check($sformatf("word%0d", i), 32'(wq[i]), 32'(expQ[i]));
    end
    check("cs_during_write", 32'(csBad), 32'd0);
    check("checksum", 32'(frameChecksum), 32'(mSum));
    check("cs_idle", 32'(LT24CS_n), 32'd1);
  endtask

  initial begin
    int n;
    int r;
    int x;
    int y;

    // Reset state.
    @(negedge clock);
    check("rst_ready", 32'(pixelReady), 32'd0);
    check("rst_cs", 32'(LT24CS_n), 32'd1);
    check("rst_rs", 32'(LT24RS), 32'd1);
    check("rst_wr", 32'(LT24Wr_n), 32'd1);
    check("rst_data", 32'(LT24Data), 32'd0);
    check("rst_sum", 32'(frameChecksum), 32'd0);
    globalReset_n = 1'b1;
    @(negedge clock);
    check("ready_after_rst", 32'(pixelReady), 32'd1);

    // Preamble, then sequential continuation, row wrap, frame wrap and a jump.
    sendPixel(10, 50, 16'hF800);
    sendPixel(11, 50, 16'h07E0);
    sendPixel(239, 50, 16'h1111);
    sendPixel(0, 51, 16'h2222);
    sendPixel(239, 319, 16'h3333);
    sendPixel(0, 0, 16'h4444);
    sendPixel(11, 50, 16'h5555);
    sendPixel(5, 5, 16'h6666);

    // Out-of-range pixels are dropped and break the sequence.
    sendPixel(240, 7, 16'h7777);
    sendPixel(6, 5, 16'h8888);
    sendPixel(241, 0, 16'h9999);
    sendPixel(7, 5, 16'hAAAA);

    // Checksum restart at origin.
    sendPixel(0, 0, 16'h1234);
    sendPixel(1, 0, 16'h0001);
`ifdef LT24_PIXEL_CHECKSUM_EN
    check("checksum_directed", 32'(frameChecksum), 32'h2469);
`else
    check("checksum_disabled", 32'(frameChecksum), 32'h0000);
`endif

    // Reset during a write low phase.
    xAddr = 8'd100;
    yAddr = 9'd100;
    pixelData = 16'hBEEF;
    pixelWrite = 1'b1;
    @(negedge clock);
    pixelWrite = 1'b0;
    n = 0;
    while (LT24Wr_n && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("midrst_in_wrlow", 32'(LT24Wr_n), 32'd0);
    globalReset_n = 1'b0;
    #1;
    check("midrst_wr", 32'(LT24Wr_n), 32'd1);
    check("midrst_cs", 32'(LT24CS_n), 32'd1);
    check("midrst_ready", 32'(pixelReady), 32'd0);
    mSeqValid = 1'b0;
    mSum = 16'h0000;
    @(negedge clock);
    globalReset_n = 1'b1;
    @(negedge clock);
    sendPixel(11, 50, 16'hCAFE);

    // Random pixels biased toward continuing the raster.
    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6 && mSeqValid) begin
        x = mNextIdx % W;
        y = mNextIdx / W;
      end else if (r == 8) begin
        x = W - 1;
        y = int'($urandom_range(0, H - 1));
      end else if (r == 9) begin
        if ($urandom_range(0, 1) == 0) begin
          x = int'($urandom_range(W, 255));
          y = int'($urandom_range(0, 511));
        end else begin
          x = int'($urandom_range(0, 255));
          y = int'($urandom_range(H, 511));
        end
      end else begin
        x = int'($urandom_range(0, W - 1));
        y = int'($urandom_range(0, H - 1));
      end
      sendPixel(x, y, 16'($urandom()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
